mem_responder: RTL

- Memory-side responder serving the multicycle CPU's load/store requests over a req/ack handshake.
- Internal word-organised RAM with a programmable wait-state count.
- RAM has no byte enables, so byte and halfword stores are done as read-modify-write.
- Sits between the CPU address/data muxes and storage; replaces the fixed-latency memory when variable latency is needed.

---
 rtl/mem_responder.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Word-organised RAM responder with req/ack handshake, programmable wait states and
// read-modify-write sub-word stores. Define MEM_ALIGN_CHECK_EN to flag misaligned accesses.
module mem_responder #(
    parameter int unsigned ADDR_BITS   = 8,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int unsigned Depth = 2 ** ADDR_BITS;
    localparam int unsigned CntW  = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam logic [CntW-1:0] WaitLast = (WAIT_STATES > 0) ? CntW'(WAIT_STATES - 1) : '0;

    typedef enum logic [2:0] {StIdle, StWait, StAccess, StMerge, StDone} state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   we_q;
    logic [1:0]             size_q;
    logic [ADDR_BITS+1:0]   addr_q;
    logic [31:0]            wdata_q;
    logic [31:0]            rd_word_q;
    logic [31:0]            rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic [31:0]            mem_q [Depth];

    logic                   capture;
    logic                   mem_we;
    logic [31:0]            mem_wdata;
    logic [ADDR_BITS-1:0]   idx;
    logic [1:0]             lane;
    logic [31:0]            mem_rd;
    logic                   sub_word;
    logic                   mis;
    logic [31:0]            load_val;
    logic [31:0]            merge_val;

    // Upper address bits wrap; only the word index and lane bits are kept.
    logic unused_addr;
    assign unused_addr = ^addr_i[31:ADDR_BITS+2];

    assign idx      = addr_q[ADDR_BITS+1:2];
    assign lane     = addr_q[1:0];
    assign mem_rd   = mem_q[idx];
    assign sub_word = (size_q == 2'b01) || (size_q == 2'b10);

`ifdef MEM_ALIGN_CHECK_EN
    assign mis = ((size_q == 2'b01) && addr_q[0]) ||
                 ((size_q == 2'b00 || size_q == 2'b11) && (addr_q[1:0] != 2'b00));
`else
    assign mis = 1'b0;
`endif

    always_comb begin
        load_val = mem_rd;
        unique case (size_q)
            2'b01:   load_val = {16'h0000, addr_q[1] ? mem_rd[31:16] : mem_rd[15:0]};
            2'b10:   load_val = {24'h000000, mem_rd[{lane, 3'b000} +: 8]};
            default: load_val = mem_rd;
        endcase
    end

    always_comb begin
        merge_val = rd_word_q;
        if (size_q == 2'b01) begin
            if (addr_q[1]) merge_val[31:16] = wdata_q[15:0];
            else           merge_val[15:0]  = wdata_q[15:0];
        end else if (size_q == 2'b10) begin
            merge_val[{lane, 3'b000} +: 8] = wdata_q[7:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        capture   = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        unique case (state_q)
            StIdle: begin
                if (req_i) begin
                    capture = 1'b1;
                    state_d = (WAIT_STATES == 0) ? StAccess : StWait;
                end
            end
            StWait: begin
                if (cnt_q == WaitLast) begin
                    cnt_d   = '0;
                    state_d = StAccess;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StAccess: begin
                if (we_q && sub_word) begin
                    state_d = StMerge;
                end else begin
                    state_d = StDone;
                    err_d   = mis;
                    if (we_q) begin
                        mem_we    = !mis;
                        mem_wdata = wdata_q;
                    end else if (!mis) begin
                        rdata_d = load_val;
                    end
                end
            end
            StMerge: begin
                mem_we    = !mis;
                mem_wdata = merge_val;
                err_d     = mis;
                state_d   = StDone;
            end
            StDone: begin
                err_d   = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            we_q      <= 1'b0;
            size_q    <= 2'b00;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_word_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (capture) begin
                we_q    <= we_i;
                size_q  <= size_i;
                addr_q  <= addr_i[ADDR_BITS+1:0];
                wdata_q <= wdata_i;
            end
            if (state_q == StAccess) rd_word_q <= mem_rd;
        end
    end

    // Array contents survive reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) mem_q[idx] <= mem_wdata;
    end

    assign ack_o   = (state_q == StDone);
    assign rdata_o = rdata_q;
    assign err_o   = err_q;

endmodule
